// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 serial receiver with mid-bit sampling.
// Optional even-parity (8E1) framing is enabled by defining UART_PARITY_EN.
// dato/rx_flat feed the byte-to-word assembler; frame_err/parity_err are
// one-cycle pulses and never coincide with rx_flat.
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 434,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] dato,
    output logic       rx_flat,
    output logic       frame_err,
    output logic       parity_err,
    output logic       rx_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    // Sample points: half a bit into the start bit, then once per full bit.
    localparam logic [CNT_W-1:0] L_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] L_FULL = CNT_W'(CLKS_PER_BIT - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic             r_sync1;
    logic             r_rx_s;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [2:0]       r_bit_idx;
    logic [2:0]       w_bit_next;
    logic [7:0]       r_shift;
    logic [7:0]       w_shift_next;
    logic [7:0]       r_dato;
    logic [7:0]       w_dato_next;
    logic             r_flat;
    logic             w_flat_next;
    logic             r_ferr;
    logic             w_ferr_next;
    logic             r_perr;
    logic             w_perr_next;
    logic             w_par_ok;
`ifdef UART_PARITY_EN
    logic             r_parity;
    logic             w_parity_next;
`endif

    // Two-flop synchroniser for the asynchronous line; idles high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_rx_s  <= r_sync1;
        end
    end

`ifdef UART_PARITY_EN
    // Even parity: data bits plus parity bit must XOR to zero.
    assign w_par_ok = ~(^{r_shift, r_parity});
`else
    assign w_par_ok = 1'b1;
`endif

    // Next-state, datapath and pulse decode for the receive FSM.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt + CNT_W'(1);
        w_bit_next   = r_bit_idx;
        w_shift_next = r_shift;
        w_dato_next  = r_dato;
        w_flat_next  = 1'b0;
        w_ferr_next  = 1'b0;
        w_perr_next  = 1'b0;
`ifdef UART_PARITY_EN
        w_parity_next = r_parity;
`endif
        case (r_state)
            S_IDLE: begin
                w_cnt_next = '0;
                if (!r_rx_s) begin
                    w_state_next = S_START;
                end
            end
            S_START: begin
                if (r_cnt == L_HALF) begin
                    w_cnt_next = '0;
                    w_bit_next = 3'd0;
                    // A line that is high again at mid start bit was a glitch.
                    w_state_next = r_rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_cnt == L_FULL) begin
                    w_cnt_next   = '0;
                    w_shift_next = {r_rx_s, r_shift[7:1]};
                    w_bit_next   = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
                        w_state_next = S_PARITY;
`else
                        w_state_next = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
                if (r_cnt == L_FULL) begin
                    w_cnt_next    = '0;
                    w_parity_next = r_rx_s;
                    w_state_next  = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (r_cnt == L_FULL) begin
                    w_cnt_next = '0;
                    if (!r_rx_s) begin
                        // Framing error wins over parity; wait out a break.
                        w_ferr_next  = 1'b1;
                        w_state_next = S_WAIT_IDLE;
                    end else if (!w_par_ok) begin
                        w_perr_next  = 1'b1;
                        w_state_next = S_IDLE;
                    end else begin
                        w_dato_next  = r_shift;
                        w_flat_next  = 1'b1;
                        w_state_next = S_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                w_cnt_next = '0;
                if (r_rx_s) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_cnt_next   = '0;
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs; reset aborts any frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
            r_dato    <= 8'h00;
            r_flat    <= 1'b0;
            r_ferr    <= 1'b0;
            r_perr    <= 1'b0;
`ifdef UART_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_bit_idx <= w_bit_next;
            r_shift   <= w_shift_next;
            r_dato    <= w_dato_next;
            r_flat    <= w_flat_next;
            r_ferr    <= w_ferr_next;
            r_perr    <= w_perr_next;
`ifdef UART_PARITY_EN
            r_parity  <= w_parity_next;
`endif
        end
    end

    assign dato       = r_dato;
    assign rx_flat    = r_flat;
    assign frame_err  = r_ferr;
    assign parity_err = r_perr;
    assign rx_busy    = (r_state != S_IDLE);

endmodule
